// File: rtl/counter_ctrl_pkg.sv
// counter_ctrl_pkg: command/state encodings and default widths for the counter sequencer.
package counter_ctrl_pkg;
  localparam int WIDTH_DEF  = 16;
  localparam int STEP_W_DEF = 8;
  typedef enum logic [1:0] {OP_NOP, OP_LOAD, OP_UP, OP_DOWN} cmd_op_e;
  typedef enum logic [1:0] {IDLE, LOAD, RUN} ctrl_state_e;
endpackage

// File: rtl/counter_ctrl.sv
// counter_ctrl: turns LOAD/UP/DOWN/NOP commands into cycle-exact controls for a 16-bit up/down counter.
module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int STEP_W = STEP_W_DEF
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_abort,
  output logic [WIDTH-1:0] data_in,
  output logic             ld_cnt,
  output logic             updn_cnt,
  output logic             count_enb,
  output logic             busy,
  output logic             done
);
  localparam logic [STEP_W-1:0] ONE = STEP_W'(1);
  ctrl_state_e       state_q, state_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [WIDTH-1:0]  data_in_q, data_in_d;
  logic              ld_cnt_q, ld_cnt_d, updn_q, updn_d, count_enb_q, count_enb_d, done_q, done_d;
  cmd_op_e           op;
  logic [STEP_W-1:0] n;
  logic              accept;
  assign op        = cmd_op_e'(cmd_op);
  assign n         = cmd_data[STEP_W-1:0];
  assign cmd_ready = (state_q == IDLE) && !cmd_abort && rst_;
  assign accept    = cmd_valid && cmd_ready;
  assign busy      = state_q != IDLE;
  assign data_in   = data_in_q;
  assign ld_cnt    = ld_cnt_q;
  assign updn_cnt  = updn_q;
  assign count_enb = count_enb_q;
  assign done      = done_q;
  // count_enb is raised on accept, so a RUN entered with step=N-1 yields exactly N enabled cycles
  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    data_in_d   = data_in_q;
    updn_d      = updn_q;
    ld_cnt_d    = 1'b0;
    count_enb_d = 1'b0;
    done_d      = 1'b0;
    case (state_q)
      IDLE: if (accept) begin
        if (op == OP_LOAD) begin
          state_d   = LOAD;
          ld_cnt_d  = 1'b1;
          data_in_d = cmd_data;
        end else if (op != OP_NOP && n != '0) begin
          state_d     = RUN;
          count_enb_d = 1'b1;
          updn_d      = op == OP_UP;
          step_d      = n - ONE;
        end else begin
          done_d = 1'b1;
        end
      end
      LOAD: begin
        state_d = IDLE;
        done_d  = !cmd_abort;
      end
      RUN: if (cmd_abort) begin
        state_d = IDLE;
        step_d  = '0;
      end else if (step_q == '0) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end else begin
        step_d      = step_q - ONE;
        count_enb_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q     <= IDLE;
      step_q      <= '0;
      data_in_q   <= '0;
      ld_cnt_q    <= 1'b0;
      updn_q      <= 1'b0;
      count_enb_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      data_in_q   <= data_in_d;
      ld_cnt_q    <= ld_cnt_d;
      updn_q      <= updn_d;
      count_enb_q <= count_enb_d;
      done_q      <= done_d;
    end
  end
endmodule
